// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline blocks.
package mips_pkg;

   localparam int unsigned WORD_W = 32;

   // Default reset PC and bubble word (sll $0,$0,0 encodes as all zeros)
   localparam logic [WORD_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   // Word-align a redirect target by clearing the byte-offset bits
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble beats hold beats load.
module ifid_reg
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble_i,
   input  logic              hold_i,
   input  logic [WORD_W-1:0] instr_i,
   input  logic [WORD_W-1:0] pc4_i,
   output logic [WORD_W-1:0] instr_o,
   output logic [WORD_W-1:0] pc4_o,
   output logic              valid_o
);

   logic [WORD_W-1:0] instr_q, instr_d;
   logic [WORD_W-1:0] pc4_q, pc4_d;
   logic              valid_q, valid_d;

   // Select bubble, hold or fresh load for the next IF/ID contents
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (bubble_i) begin
         // pc4 is left alone on a bubble; only instr and valid are squashed
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!hold_i) begin
         instr_d = instr_i;
         pc4_d   = pc4_i;
         valid_d = 1'b1;
      end
   end

   // IF/ID state register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, misalign flag, fetch counter.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_target,
   input  logic              jump,
   input  logic [WORD_W-1:0] jump_target,
   output logic [WORD_W-1:0] pc_out,
   input  logic [WORD_W-1:0] pc_seq,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] ifid_instr,
   output logic [WORD_W-1:0] ifid_pc4,
   output logic              ifid_valid,
   output logic              misalign,
   output logic [WORD_W-1:0] fetch_count
);

   logic [WORD_W-1:0] pc_q, pc_d;
   logic              misalign_q, misalign_d;
   logic [WORD_W-1:0] fetch_count_q, fetch_count_d;
   logic              redirect;
   logic [WORD_W-1:0] redirect_target;
   logic              ifid_load;

   // Pick the redirect source; branch (EX) outranks jump (ID)
   always_comb begin
      redirect        = branch_taken | jump;
      redirect_target = branch_taken ? branch_target : jump_target;
   end

   // Next-PC mux and misalign detection on the selected target only
   always_comb begin
      pc_d       = pc_seq;
      misalign_d = 1'b0;
      if (redirect) begin
         pc_d       = word_align(redirect_target);
         misalign_d = |redirect_target[1:0];
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   // A real instruction enters IF/ID only when neither bubbled nor held
   always_comb begin
      ifid_load     = !(redirect | flush) && !stall;
      fetch_count_d = ifid_load ? fetch_count_q + 32'd1 : fetch_count_q;
   end

   // PC, misalign pulse and fetch counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         misalign_q    <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         pc_q          <= pc_d;
         misalign_q    <= misalign_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk      (clk),
      .rst      (rst),
      .bubble_i (redirect | flush),
      .hold_i   (stall),
      .instr_i  (imem_rdata),
      .pc4_i    (pc_seq),
      .instr_o  (ifid_instr),
      .pc4_o    (ifid_pc4),
      .valid_o  (ifid_valid)
   );

   assign pc_out      = pc_q;
   assign misalign    = misalign_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with the PC adder and a simple imem in the loop.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, branch_taken, jump;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc_out, pc_seq, imem_rdata;
   logic [31:0] ifid_instr, ifid_pc4, fetch_count;
   logic        ifid_valid, misalign;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // External adder and instruction memory: word at pc is pc ^ 32'hDEAD_0000
   assign pc_seq     = pc_out + 32'd4;
   assign imem_rdata = pc_out ^ 32'hDEAD_0000;

   fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc_out        (pc_out),
      .pc_seq        (pc_seq),
      .imem_rdata    (imem_rdata),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .misalign      (misalign),
      .fetch_count   (fetch_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 0; flush = 0; branch_taken = 0; jump = 0;
      branch_target = '0; jump_target = '0;
      #2;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want %h", ifid_instr, 32'h0); end
      checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h want %h", ifid_pc4, 32'h0); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      tick();
      checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL run_pc1 got %h want %h", pc_out, 32'h4); end
      checks++; if (ifid_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL run_instr1 got %h want %h", ifid_instr, 32'hDEAD_0000); end
      checks++; if (ifid_pc4 !== 32'h4) begin errors++; $display("FAIL run_pc4_1 got %h want %h", ifid_pc4, 32'h4); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL run_valid1 got %b want 1", ifid_valid); end
      checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL run_count1 got %0d want 1", fetch_count); end
      tick();
      checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL run_pc2 got %h want %h", pc_out, 32'h8); end
      checks++; if (ifid_instr !== 32'hDEAD_0004) begin errors++; $display("FAIL run_instr2 got %h want %h", ifid_instr, 32'hDEAD_0004); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL stall_pc got %h want %h", pc_out, 32'h8); end
         checks++; if (ifid_instr !== 32'hDEAD_0004) begin errors++; $display("FAIL stall_instr got %h want %h", ifid_instr, 32'hDEAD_0004); end
         checks++; if (ifid_pc4 !== 32'h8) begin errors++; $display("FAIL stall_pc4 got %h want %h", ifid_pc4, 32'h8); end
         checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", ifid_valid); end
         checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count got %0d want 2", fetch_count); end
      end
      stall = 1'b0;
      tick();
      checks++; if (pc_out !== 32'hC) begin errors++; $display("FAIL unstall_pc got %h want %h", pc_out, 32'hC); end
      checks++; if (ifid_instr !== 32'hDEAD_0008) begin errors++; $display("FAIL unstall_instr got %h want %h", ifid_instr, 32'hDEAD_0008); end
      tick();
      checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL run_pc4 got %h want %h", pc_out, 32'h10); end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL run_count4 got %0d want 4", fetch_count); end
   endtask

   task automatic test_branch_over_stall();
      branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h40) begin errors++; $display("FAIL br_pc got %h want %h", pc_out, 32'h40); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b want 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL br_instr got %h want %h", ifid_instr, 32'h0); end
      checks++; if (ifid_pc4 !== 32'h10) begin errors++; $display("FAIL br_pc4 got %h want %h", ifid_pc4, 32'h10); end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL br_count got %0d want 4", fetch_count); end
      branch_taken = 1'b0; stall = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h44) begin errors++; $display("FAIL br_next_pc got %h want %h", pc_out, 32'h44); end
      checks++; if (ifid_instr !== 32'hDEAD_0040) begin errors++; $display("FAIL br_next_instr got %h want %h", ifid_instr, 32'hDEAD_0040); end
      checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL br_next_count got %0d want 5", fetch_count); end
   endtask

   task automatic test_priority_misalign();
      branch_taken = 1'b1; branch_target = 32'h100; jump = 1'b1; jump_target = 32'h200;
      tick();
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL prio_pc got %h want %h", pc_out, 32'h100); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL prio_misalign got %b want 0", misalign); end
      branch_taken = 1'b0; jump_target = 32'h203;
      tick();
      checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL jmp_pc got %h want %h", pc_out, 32'h200); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL jmp_misalign got %b want 1", misalign); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL jmp_valid got %b want 0", ifid_valid); end
      jump = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL jmp_next_pc got %h want %h", pc_out, 32'h204); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b want 0", misalign); end
      checks++; if (ifid_instr !== 32'hDEAD_0200) begin errors++; $display("FAIL jmp_next_instr got %h want %h", ifid_instr, 32'hDEAD_0200); end
      checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL jmp_next_count got %0d want 6", fetch_count); end
      // Branch target misaligned, jump target misaligned too but unselected
      branch_taken = 1'b1; branch_target = 32'h301; jump = 1'b1; jump_target = 32'h402;
      tick();
      checks++; if (pc_out !== 32'h300) begin errors++; $display("FAIL br_align_pc got %h want %h", pc_out, 32'h300); end
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL br_misalign got %b want 1", misalign); end
      branch_taken = 1'b0; jump = 1'b0;
   endtask

   task automatic test_flush_wrap();
      jump = 1'b1; jump_target = 32'h20;
      tick();
      jump = 1'b0; flush = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h24) begin errors++; $display("FAIL flush_pc got %h want %h", pc_out, 32'h24); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", ifid_valid); end
      checks++; if (ifid_pc4 !== 32'h204) begin errors++; $display("FAIL flush_pc4 got %h want %h", ifid_pc4, 32'h204); end
      stall = 1'b1;
      tick();
      checks++; if (pc_out !== 32'h24) begin errors++; $display("FAIL flush_stall_pc got %h want %h", pc_out, 32'h24); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_valid got %b want 0", ifid_valid); end
      flush = 1'b0; stall = 1'b0;
      tick();
      checks++; if (ifid_instr !== 32'hDEAD_0024) begin errors++; $display("FAIL post_flush_instr got %h want %h", ifid_instr, 32'hDEAD_0024); end
      checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL post_flush_count got %0d want 7", fetch_count); end
      jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      tick();
      checks++; if (pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL preset_pc got %h want %h", pc_out, 32'hFFFF_FFFC); end
      jump = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", pc_out, 32'h0); end
      checks++; if (ifid_instr !== 32'h2152_FFFC) begin errors++; $display("FAIL wrap_instr got %h want %h", ifid_instr, 32'h2152_FFFC); end
      checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want %h", ifid_pc4, 32'h0); end
      checks++; if (fetch_count !== 32'd8) begin errors++; $display("FAIL wrap_count got %0d want 8", fetch_count); end
   endtask

   task automatic test_async_reset();
      tick();
      #2;
      rst = 1'b1;
      #1;
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL async_pc got %h want %h", pc_out, 32'h0); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL async_instr got %h want %h", ifid_instr, 32'h0); end
      checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL async_pc4 got %h want %h", ifid_pc4, 32'h0); end
      checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL async_count got %0d want 0", fetch_count); end
      rst = 1'b0;
      tick();
      checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL rerun_pc got %h want %h", pc_out, 32'h4); end
      checks++; if (ifid_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL rerun_instr got %h want %h", ifid_instr, 32'hDEAD_0000); end
      checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL rerun_count got %0d want 1", fetch_count); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_stall();
      test_branch_over_stall();
      test_priority_misalign();
      test_flush_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
